// File: rtl/dsm_pkg.sv
// Shared constants and arithmetic helpers for the streaming delta-sigma DAC.
package dsm_pkg;

  localparam int ORDER_FIRST  = 1;
  localparam int ORDER_SECOND = 2;

  // A saturated sum is carried at a fixed wide width.
  // The caller keeps only its own low bits.
  typedef struct packed {
    logic signed [63:0] value;
    logic               clamped;
  } sat_result_t;

  // Adds two sign-extended operands and clamps the result to a signed acc_width range.
  // Landing exactly on a limit is not reported as a clamp.
  function automatic sat_result_t sat_add(input logic signed [63:0] a,
                                          input logic signed [63:0] b,
                                          input int                 acc_width);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_result_t        res;
    sum         = a + b;
    hi          = (64'sd1 <<< (acc_width - 1)) - 64'sd1;
    lo          = -hi - 64'sd1;
    res.value   = sum;
    res.clamped = 1'b0;
    if (sum > hi) begin
      res.value   = hi;
      res.clamped = 1'b1;
    end else if (sum < lo) begin
      res.value   = lo;
      res.clamped = 1'b1;
    end
    return res;
  endfunction

  // Maps the quantizer bit to the feedback value.
  // q = 1 gives +mag and q = 0 gives -mag.
  function automatic logic signed [63:0] fb_value(input logic               q,
                                                  input logic signed [63:0] mag);
    return q ? mag : -mag;
  endfunction

endpackage

// File: rtl/dsm_sat_integrator.sv
// Saturating integrator stage.
// On each enabled cycle it adds a signed delta to its state.
// clamp pulses whenever that update had to be limited.
module dsm_sat_integrator #(
  parameter int IN_WIDTH  = 10,
  parameter int ACC_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic signed [IN_WIDTH-1:0]  delta,
  output logic signed [ACC_WIDTH-1:0] state,
  output logic                        clamp
);
  import dsm_pkg::*;

  sat_result_t next_sum;
  logic        unused_hi_bits;

  // Forms the clamped next state from the current state and the incoming delta.
  always_comb begin
    next_sum = sat_add(64'(state), 64'(delta), ACC_WIDTH);
  end

  assign clamp          = en & next_sum.clamped;
  assign unused_hi_bits = ^next_sum.value[63:ACC_WIDTH];

  // The state register advances only on enabled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (en) begin
      state <= next_sum.value[ACC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/dsm_dac_stream.sv
// Streaming single-bit delta-sigma DAC.
// PCM samples arrive over valid/ready.
// A one-deep pending buffer feeds the sample being modulated.
// Each sample is held for OSR enabled cycles.
// The modulator loop is first or second order, built from saturating integrators.
module dsm_dac_stream #(
  parameter int DATA_WIDTH   = 4,
  parameter int ORDER        = 1,
  parameter int OSR          = 4,
  parameter int ACC_WIDTH    = DATA_WIDTH + 4,
  parameter int FEEDBACK_MAG = 1 << (DATA_WIDTH - 1)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_clr_flags,
  output logic                         o_dac_bitstream,
  output logic                         o_overload,
  output logic                         o_underrun
);
  import dsm_pkg::*;

  localparam int                   SUM_WIDTH = ACC_WIDTH + 2;
  localparam int                   CNT_WIDTH = $clog2(OSR);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(OSR - 1);

  if (ORDER != ORDER_FIRST && ORDER != ORDER_SECOND) begin : g_bad_order
    $error("dsm_dac_stream: ORDER must be 1 or 2");
  end
  if (OSR < 2) begin : g_bad_osr
    $error("dsm_dac_stream: OSR must be at least 2");
  end

  logic signed [DATA_WIDTH-1:0] cur;
  logic signed [DATA_WIDTH-1:0] pend;
  logic                         pend_vld;
  logic [CNT_WIDTH-1:0]         cnt;
  logic                         accept;
  logic                         boundary;
  logic                         underrun_evt;
  logic                         overload_evt;
  logic                         q;
  logic signed [ACC_WIDTH-1:0]  u1;
  logic                         clamp1;
  logic signed [SUM_WIDTH-1:0]  fb;
  logic signed [SUM_WIDTH-1:0]  delta1;

  assign o_ready      = ~pend_vld;
  assign accept       = i_valid & ~pend_vld;
  assign boundary     = i_en & (cnt == CNT_LAST);
  assign underrun_evt = boundary & ~pend_vld & ~accept;

  assign fb     = SUM_WIDTH'(fb_value(q, 64'(FEEDBACK_MAG)));
  assign delta1 = SUM_WIDTH'(cur) - fb;

  dsm_sat_integrator #(
    .IN_WIDTH  (SUM_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_int1 (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .en    (i_en),
    .delta (delta1),
    .state (u1),
    .clamp (clamp1)
  );

  if (ORDER == ORDER_SECOND) begin : g_second
    logic signed [ACC_WIDTH-1:0] u2;
    logic                        clamp2;
    logic signed [SUM_WIDTH-1:0] fb2;
    logic signed [SUM_WIDTH-1:0] delta2;

    assign fb2    = SUM_WIDTH'(fb_value(q, 64'(2 * FEEDBACK_MAG)));
    assign delta2 = SUM_WIDTH'(u1) - fb2;

    dsm_sat_integrator #(
      .IN_WIDTH  (SUM_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_int2 (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .en    (i_en),
      .delta (delta2),
      .state (u2),
      .clamp (clamp2)
    );

    assign q            = ~u2[ACC_WIDTH-1];
    assign overload_evt = clamp1 | clamp2;
  end else begin : g_first
    assign q            = ~u1[ACC_WIDTH-1];
    assign overload_evt = clamp1;
  end

  // The output bit depends only on the last integrator's register, so it is glitch-free.
  assign o_dac_bitstream = q;

  // Sample-period counter and the cur/pend buffer.
  // At a boundary, cur takes pend, or takes a same-cycle bypass sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt      <= '0;
      cur      <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
    end else begin
      if (i_en) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
      if (boundary) begin
        if (pend_vld) begin
          cur      <= pend;
          pend_vld <= 1'b0;
        end else if (accept) begin
          cur <= i_data;
        end
      end
      if (accept && !boundary) begin
        pend     <= i_data;
        pend_vld <= 1'b1;
      end
    end
  end

  // Sticky status flags.
  // A set event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overload <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      if (overload_evt) begin
        o_overload <= 1'b1;
      end else if (i_clr_flags) begin
        o_overload <= 1'b0;
      end
      if (underrun_evt) begin
        o_underrun <= 1'b1;
      end else if (i_clr_flags) begin
        o_underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsm_dac_stream.sv
// Testbench for dsm_dac_stream.
// Three configurations share one stimulus stream:
//   index 0: first order, default widths
//   index 1: second order, default widths
//   index 2: first order, 6-bit integrator, feedback magnitude 4
// A behavioural model is compared against every DUT on every falling edge.
// Directed literal checks pin the model to hand-worked sequences.
module tb_dsm_dac_stream;
  localparam int OSR  = 4;
  localparam int NDUT = 3;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              en    = 1'b0;
  logic              valid = 1'b0;
  logic              clr   = 1'b0;
  logic signed [3:0] data  = '0;
  logic [NDUT-1:0]   ready;
  logic [NDUT-1:0]   bits;
  logic [NDUT-1:0]   ovl;
  logic [NDUT-1:0]   und;

  int checks = 0;
  int errors = 0;

  int cfg_order [NDUT] = '{1, 2, 1};
  int cfg_acc   [NDUT] = '{8, 8, 6};
  int cfg_fb    [NDUT] = '{8, 8, 4};

  int m_u1  [NDUT];
  int m_u2  [NDUT];
  bit m_ovl [NDUT];
  bit m_und;
  int m_cur;
  int m_cnt;
  int m_pend[$];

  always #5 clk = ~clk;

  dsm_dac_stream #(.ORDER(1)) dut_o1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_data(data), .i_valid(valid),
    .o_ready(ready[0]), .i_clr_flags(clr), .o_dac_bitstream(bits[0]),
    .o_overload(ovl[0]), .o_underrun(und[0]));

  dsm_dac_stream #(.ORDER(2)) dut_o2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_data(data), .i_valid(valid),
    .o_ready(ready[1]), .i_clr_flags(clr), .o_dac_bitstream(bits[1]),
    .o_overload(ovl[1]), .o_underrun(und[1]));

  dsm_dac_stream #(.ORDER(1), .ACC_WIDTH(6), .FEEDBACK_MAG(4)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_data(data), .i_valid(valid),
    .o_ready(ready[2]), .i_clr_flags(clr), .o_dac_bitstream(bits[2]),
    .o_overload(ovl[2]), .o_underrun(und[2]));

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input int d, input bit e, input bit c);
    valid = v;
    data  = 4'(d);
    en    = e;
    clr   = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int satClamp(input int v, input int w, output bit hit);
    int hi;
    int lo;
    hi  = (1 << (w - 1)) - 1;
    lo  = -(1 << (w - 1));
    hit = 1'b0;
    if (v > hi) begin
      hit = 1'b1;
      return hi;
    end
    if (v < lo) begin
      hit = 1'b1;
      return lo;
    end
    return v;
  endfunction

  function automatic bit modelBit(input int i);
    return ((cfg_order[i] == 2) ? m_u2[i] : m_u1[i]) >= 0;
  endfunction

  task automatic modelReset();
    m_cur = 0;
    m_cnt = 0;
    m_und = 1'b0;
    m_pend.delete();
    for (int i = 0; i < NDUT; i++) begin
      m_u1[i]  = 0;
      m_u2[i]  = 0;
      m_ovl[i] = 1'b0;
    end
  endtask

  // Advances the model by one clock, using the inputs as they stood before the edge.
  task automatic modelStep();
    bit acc;
    bit bnd;
    bit c1;
    bit c2;
    int fb;
    int n1;
    int n2;
    acc = valid && (m_pend.size() == 0);
    bnd = en && (m_cnt == OSR - 1);
    for (int i = 0; i < NDUT; i++) begin
      c1 = 1'b0;
      c2 = 1'b0;
      if (en) begin
        fb = modelBit(i) ? cfg_fb[i] : -cfg_fb[i];
        n1 = satClamp(m_u1[i] + m_cur - fb, cfg_acc[i], c1);
        n2 = 0;
        if (cfg_order[i] == 2) n2 = satClamp(m_u2[i] + m_u1[i] - 2 * fb, cfg_acc[i], c2);
        m_u1[i] = n1;
        m_u2[i] = n2;
      end
      if (c1 || c2) m_ovl[i] = 1'b1;
      else if (clr) m_ovl[i] = 1'b0;
    end
    if (bnd && m_pend.size() == 0 && !acc) m_und = 1'b1;
    else if (clr) m_und = 1'b0;
    if (bnd) begin
      if (m_pend.size() != 0) m_cur = m_pend.pop_front();
      else if (acc) m_cur = int'(data);
    end else if (acc) begin
      m_pend.push_back(int'(data));
    end
    if (en) m_cnt = (m_cnt + 1) % OSR;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep();
    end
  end

  // Compares every DUT with the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        checkOutput($sformatf("model ready[%0d]", i), int'(ready[i]), int'(m_pend.size() == 0));
        checkOutput($sformatf("model bit[%0d]", i), int'(bits[i]), int'(modelBit(i)));
        checkOutput($sformatf("model overload[%0d]", i), int'(ovl[i]), int'(m_ovl[i]));
        checkOutput($sformatf("model underrun[%0d]", i), int'(und[i]), int'(m_und));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic sendSample(input int d);
    int waited;
    waited = 0;
    applyStimulus(1'b1, d, 1'b1, 1'b0);
    while (!ready[0] && waited < 20) begin
      tick();
      waited++;
    end
    if (waited >= 20) checkOutput("handshake timeout", 0, 1);
    tick();
    applyStimulus(1'b0, d, 1'b1, 1'b0);
  endtask

  int pat_alt [8]  = '{1, 0, 1, 0, 1, 0, 1, 0};
  int pat_o2  [8]  = '{1, 0, 0, 1, 1, 0, 0, 1};
  int pat_p4  [12] = '{1, 0, 1, 0, 1, 0, 1, 1, 1, 0, 1, 1};
  int waited;

  initial begin
    // Reset values
    #11;
    for (int i = 0; i < NDUT; i++) begin
      checkOutput($sformatf("reset ready[%0d]", i), int'(ready[i]), 1);
      checkOutput($sformatf("reset bit[%0d]", i), int'(bits[i]), 1);
      checkOutput($sformatf("reset overload[%0d]", i), int'(ovl[i]), 0);
      checkOutput($sformatf("reset underrun[%0d]", i), int'(und[i]), 0);
    end
    #1 rst_n = 1'b1;

    // Idle input, cur = 0: the alternating and 1,0,0,1 patterns, plus an underrun
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("zero o1 bit %0d", k), int'(bits[0]), pat_alt[k]);
      checkOutput($sformatf("zero o2 bit %0d", k), int'(bits[1]), pat_o2[k]);
      checkOutput($sformatf("zero sat bit %0d", k), int'(bits[2]), pat_alt[k]);
      tick();
    end
    checkOutput("starved underrun", int'(und[0]), 1);

    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    tick();
    checkOutput("clear underrun", int'(und[0]), 0);

    // Sample +4 goes through pend; the 6-of-8 pattern starts once it reaches cur
    applyStimulus(1'b1, 4, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      checkOutput($sformatf("plus4 o1 bit %0d", k), int'(bits[0]), pat_p4[k]);
      checkOutput($sformatf("plus4 ready %0d", k), int'(ready[0]), int'(k % 4 == 0));
      if (k < 4) checkOutput($sformatf("plus4 o2 bit %0d", k), int'(bits[1]), pat_o2[k]);
      tick();
    end
    checkOutput("plus4 no underrun", int'(und[0]), 0);

    // Back-to-back samples 3, -2, 5
    sendSample(3);
    sendSample(-2);
    sendSample(5);
    checkOutput("burst no underrun", int'(und[0]), 0);

    // Starve input: underrun appears at the first boundary with pend empty
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) tick();
    checkOutput("starve underrun", int'(und[0]), 1);

    // A clear held across a boundary: the set event wins
    applyStimulus(1'b0, 0, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("clear before boundary", int'(und[0]), 0);
    tick();
    checkOutput("set wins over clear", int'(und[0]), 1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    tick();
    checkOutput("clear after boundary", int'(und[0]), 0);

    // Bypass: a valid sample arriving in the boundary cycle goes straight to cur
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    waited = 0;
    while (m_cnt != OSR - 1 && waited < 10) begin
      tick();
      waited++;
    end
    applyStimulus(1'b1, -3, 1'b1, 1'b0);
    tick();
    checkOutput("bypass no underrun", int'(und[0]), 0);
    checkOutput("bypass ready stays high", int'(ready[0]), 1);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) tick();

    // Saturation on the 6-bit instance: cur = -8 arrives via bypass with u1 = 0
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    applyStimulus(1'b1, -8, 1'b1, 1'b0);
    tick();
    checkOutput("sat bypass no underrun", int'(und[2]), 0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      checkOutput($sformatf("sat overload after update %0d", k), int'(ovl[2]), int'(k >= 7));
      checkOutput($sformatf("sat bit after update %0d", k), int'(bits[2]), 0);
    end
    applyStimulus(1'b1, -8, 1'b1, 1'b1);
    tick();
    checkOutput("overload set wins", int'(ovl[2]), 1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    tick();
    checkOutput("overload cleared", int'(ovl[2]), 0);

    // Reset in mid-operation while a sample is being offered
    applyStimulus(1'b1, 5, 1'b1, 1'b0);
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      checkOutput($sformatf("midreset ready[%0d]", i), int'(ready[i]), 1);
      checkOutput($sformatf("midreset bit[%0d]", i), int'(bits[i]), 1);
      checkOutput($sformatf("midreset overload[%0d]", i), int'(ovl[i]), 0);
      checkOutput($sformatf("midreset underrun[%0d]", i), int'(und[i]), 0);
    end
    #1 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
